uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Receives 8N1 asynchronous serial frames (1 start bit, 8 data bits LSB first, 1 stop bit).
//  This is the receive-side companion of the uart transmitter.
//  - Input: a pin from a peer device, or looped back from our transmitter's pin.
//  - Output: each completed byte with a 1-cycle strobe, for downstream command/telemetry logic.
//  - Flags frames whose stop bit is sampled low.
// PARAMETERS
//  clocks_per_bit  16  clock cycles per serial bit; must be >= 4 (mid-bit sampling needs oversampling)
//  invert          0   1 = line idles low and all bits are inverted (matches the transmitter's invert option)
// PORTS
//  clock           in   1  system clock, all logic on rising edge
//  reset           in   1  synchronous, active-high reset
//  pin             in   1  asynchronous serial input
//  byte_received   out  8  last correctly framed byte; holds its value until the next good frame
//  received        out  1  1-cycle pulse: byte_received updated this cycle
//  framing_error   out  1  1-cycle pulse: stop bit sampled as 0, frame dropped
//  busy            out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset state: byte_received=0, received=0, framing_error=0, busy=0, state=IDLE, counters=0.
//  - reset has priority over every other event.
//  - Asserting reset mid-frame aborts the frame silently: no received or framing_error pulse.
//  Synchronizer:
//  - rx_meta <= pin ^ invert; rx_sync <= rx_meta.
//  - Both flops reset to 1 (logical idle).
//  - All decisions below use rx_sync (logical level).
//  HALF = (clocks_per_bit-1)/2 (integer division).
//  Counter: width clog2(clocks_per_bit); bit_index: 3 bits.
//  FSM (evaluated each rising edge):
//  - IDLE:  rx_sync==0 -> START, counter<=0.
//  - START: counter==HALF -> if rx_sync==0, DATA with counter<=0, bit_index<=0;
//           else IDLE (glitch rejected, no flag).
//           otherwise counter++.
//  - DATA:  counter==cpb-1 -> shift<={rx_sync,shift[7:1]}, counter<=0;
//           bit_index==7 -> STOP, else bit_index++.
//           otherwise counter++.
//  - STOP:  counter==cpb-1 -> IDLE;
//           rx_sync==1: byte_received<=shift, received<=1;
//           else framing_error<=1 and byte_received unchanged.
//           otherwise counter++.
//  received and framing_error are default-0 registers; each is high for exactly 1 cycle and never both.
//  Latency: if rx_meta first captures the start edge at edge E0, then:
//  - data bit k is sampled at edge E0+3+HALF+(k+1)*cpb;
//  - stop bit is sampled at E0+3+HALF+9*cpb;
//  - received is high in the cycle following that edge.
//  Back-to-back frames: return to IDLE occurs mid-stop-bit, so a start bit immediately following
//  the stop bit is caught with no lost frame.
//  Line held low (break): yields framing_error, then IDLE re-enters START at once.
//  - Repeats one framing_error per frame time until the line goes high; no received pulses.
//  Line changes between samples are ignored; only the single mid-bit sample counts (no majority vote).
// TESTING
//  1. cpb=4, loopback from uart transmitter, send 8'b10111001 -> one received pulse,
//     byte_received=8'hB9, framing_error never high.
//  2. cpb=4, invert=1 on both transmitter and receiver, send 8'h5A -> byte_received=8'h5A;
//     receiver with invert=0 on the same line gets no good frame.
//  3. Drive start, 8'h3C, stop=0 by hand (cpb=16) -> framing_error 1 cycle;
//     byte_received keeps previous value; no received pulse.
//  4. Low glitch of 2 cycles on idle line (cpb=16) -> busy high briefly, returns to IDLE;
//     no pulses; byte_received unchanged.
//  5. Back-to-back 8'h00, 8'hFF, 8'hA5 with no idle gap (cpb=8) -> three received pulses,
//     values in order, exactly 10*cpb cycles apart.
//  6. Assert reset during data bit 4, release, then send 8'h81 -> aborted frame produces no pulse;
//     next frame received as 8'h81; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling; byte strobed 1 cycle after the stop-bit sample.
// No backpressure: received/framing_error are single-cycle pulses that downstream must take when seen.
module uart_receiver #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter bit INVERT         = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pin_i,
  output logic [7:0] byte_received_o,
  output logic       received_o,
  output logic       framing_error_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          rcv_q, rcv_d;
  logic          fe_q, fe_d;

  // Sync flops reset to logical idle so a held-low line is not mistaken for a start bit during reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= pin_i ^ INVERT;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      rcv_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      rcv_q     <= rcv_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    rcv_d     = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is gone by mid-bit was a glitch: drop it without a flag.
        if (cnt_q == HALF) begin
          if (!rx_sync_q) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets an immediately following start edge be caught.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_sync_q) begin
            byte_d = shift_q;
            rcv_d  = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_received_o = byte_q;
  assign received_o      = rcv_q;
  assign framing_error_o = fe_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: several instances at different bit rates/polarities, each on its own line.
module tb_uart_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] pins;

  logic [7:0] byte_a, byte_b, byte_b0, byte_c, byte_d;
  logic       rcv_a, rcv_b, rcv_b0, rcv_c, rcv_d;
  logic       fe_a, fe_b, fe_b0, fe_c, fe_d;
  logic       busy_a, busy_b, busy_b0, busy_c, busy_d;

  uart_receiver #(.CLOCKS_PER_BIT(4), .INVERT(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .pin_i(pins[0]), .byte_received_o(byte_a),
    .received_o(rcv_a), .framing_error_o(fe_a), .busy_o(busy_a));
  uart_receiver #(.CLOCKS_PER_BIT(4), .INVERT(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .pin_i(pins[1]), .byte_received_o(byte_b),
    .received_o(rcv_b), .framing_error_o(fe_b), .busy_o(busy_b));
  uart_receiver #(.CLOCKS_PER_BIT(4), .INVERT(1'b0)) dut_b0 (
    .clk_i(clk), .rst_i(rst), .pin_i(pins[1]), .byte_received_o(byte_b0),
    .received_o(rcv_b0), .framing_error_o(fe_b0), .busy_o(busy_b0));
  uart_receiver #(.CLOCKS_PER_BIT(16), .INVERT(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst), .pin_i(pins[2]), .byte_received_o(byte_c),
    .received_o(rcv_c), .framing_error_o(fe_c), .busy_o(busy_c));
  uart_receiver #(.CLOCKS_PER_BIT(8), .INVERT(1'b0)) dut_d (
    .clk_i(clk), .rst_i(rst), .pin_i(pins[3]), .byte_received_o(byte_d),
    .received_o(rcv_d), .framing_error_o(fe_d), .busy_o(busy_d));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled mid-cycle.
  int rx_a = 0, fe_a_n = 0, t_a = 0;
  int rx_b = 0, fe_b_n = 0, t_b = 0, rx_b0 = 0;
  int rx_c = 0, fe_c_n = 0, t_c = 0, busy_c_n = 0;
  int rx_d = 0, fe_d_n = 0, both_n = 0;
  int         t_d [0:7];
  logic [7:0] v_d [0:7];

  always @(negedge clk) begin
    if (rcv_a) begin rx_a++; t_a = cyc; end
    if (fe_a) fe_a_n++;
    if (rcv_b) begin rx_b++; t_b = cyc; end
    if (fe_b) fe_b_n++;
    if (rcv_b0) rx_b0++;
    if (rcv_c) begin rx_c++; t_c = cyc; end
    if (fe_c) fe_c_n++;
    if (busy_c) busy_c_n++;
    if (rcv_d) begin
      if (rx_d < 8) begin
        t_d[rx_d] = cyc;
        v_d[rx_d] = byte_d;
      end
      rx_d++;
    end
    if (fe_d) fe_d_n++;
    if ((rcv_a & fe_a) | (rcv_b & fe_b) | (rcv_b0 & fe_b0) | (rcv_c & fe_c) | (rcv_d & fe_d))
      both_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input int idx, input logic v, input int cpb);
    pins[idx] = v;
    tick(cpb);
  endtask

  // start_cyc is the edge at which the receiver's first sync flop captures the start bit.
  task automatic send(input int idx, input logic [7:0] d, input logic stop, input int cpb, input logic inv);
    start_cyc = cyc + 1;
    send_bit(idx, inv, cpb);
    for (int i = 0; i < 8; i++) send_bit(idx, d[i] ^ inv, cpb);
    send_bit(idx, stop ^ inv, cpb);
    pins[idx] = ~inv;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int s0;
  int busy0;

  initial begin
    rst  = 1'b1;
    pins = 4'b1101;
    tick(3);
    check("reset_bytes", {byte_a, byte_b, byte_c, byte_d}, 32'h0);
    check("reset_rcv", {rcv_a, rcv_b, rcv_b0, rcv_c, rcv_d}, 32'h0);
    check("reset_fe", {fe_a, fe_b, fe_b0, fe_c, fe_d}, 32'h0);
    check("reset_busy", {busy_a, busy_b, busy_b0, busy_c, busy_d}, 32'h0);

    // Inverted line: the non-inverting receiver walks through break frames and must never frame 8'h5A.
    rst = 1'b0;
    tick(41);
    send(1, 8'h5A, 1'b1, 4, 1'b1);
    tick(20);
    check("inv_rx_count", rx_b, 1);
    check("inv_byte", byte_b, 8'h5A);
    check("inv_latency", t_b - start_cyc, 40);
    check("inv_fe_count", fe_b_n, 0);
    check("noninv_rx_count", rx_b0, 0);

    send(0, 8'b10111001, 1'b1, 4, 1'b0);
    tick(20);
    check("loop_rx_count", rx_a, 1);
    check("loop_byte", byte_a, 8'hB9);
    check("loop_latency", t_a - start_cyc, 40);
    check("loop_fe_count", fe_a_n, 0);

    send(2, 8'h96, 1'b1, 16, 1'b0);
    tick(40);
    check("c_good_count", rx_c, 1);
    check("c_good_byte", byte_c, 8'h96);
    check("c_good_latency", t_c - start_cyc, 154);

    send(2, 8'h3C, 1'b0, 16, 1'b0);
    tick(40);
    check("ferr_count", fe_c_n, 1);
    check("ferr_no_rx", rx_c, 1);
    check("ferr_byte_kept", byte_c, 8'h96);

    busy0 = busy_c_n;
    pins[2] = 1'b0;
    tick(2);
    pins[2] = 1'b1;
    tick(30);
    check("glitch_busy_cycles", busy_c_n - busy0, 8);
    check("glitch_idle", busy_c, 1'b0);
    check("glitch_no_rx", rx_c, 1);
    check("glitch_no_fe", fe_c_n, 1);
    check("glitch_byte_kept", byte_c, 8'h96);

    s0 = cyc + 1;
    send(3, 8'h00, 1'b1, 8, 1'b0);
    send(3, 8'hFF, 1'b1, 8, 1'b0);
    send(3, 8'hA5, 1'b1, 8, 1'b0);
    tick(30);
    check("b2b_count", rx_d, 3);
    check("b2b_val0", v_d[0], 8'h00);
    check("b2b_val1", v_d[1], 8'hFF);
    check("b2b_val2", v_d[2], 8'hA5);
    check("b2b_latency", t_d[0] - s0, 78);
    check("b2b_gap01", t_d[1] - t_d[0], 80);
    check("b2b_gap12", t_d[2] - t_d[1], 80);
    check("b2b_fe", fe_d_n, 0);

    // Abort a frame part-way through data bit 4.
    send_bit(3, 1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(3, i[0], 8);
    pins[3] = 1'b1;
    tick(4);
    check("abort_busy_before", busy_d, 1'b1);
    rst = 1'b1;
    tick(2);
    check("rst_mid_bytes", {byte_a, byte_b, byte_c, byte_d}, 32'h0);
    check("rst_mid_pulses", {rcv_a, rcv_b, rcv_c, rcv_d, fe_a, fe_b, fe_c, fe_d}, 32'h0);
    check("rst_mid_busy", {busy_a, busy_b, busy_c, busy_d}, 32'h0);
    rst = 1'b0;
    tick(100);
    check("abort_no_rx", rx_d, 3);
    check("abort_no_fe", fe_d_n, 0);
    check("abort_idle", busy_d, 1'b0);
    check("abort_byte_reset", byte_d, 8'h00);

    send(3, 8'h81, 1'b1, 8, 1'b0);
    tick(30);
    check("after_abort_count", rx_d, 4);
    check("after_abort_byte", byte_d, 8'h81);
    check("after_abort_val", v_d[3], 8'h81);
    check("never_both", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
